// File: rtl/reg_file_cfg.sv
// ---------------------------------------------------------------------------
// reg_file_cfg
//
// Parametrised configuration register file. It sits between the system
// controller and the UART / clock-divider configuration consumers.
//
// Features:
//   - separate write and read ports
//   - byte-strobed writes
//   - per-register write protection (WP_MASK)
//   - programmable reset values (RESET_VECTOR)
//   - 1- or 2-cycle read pipeline (RD_LATENCY)
//   - access-error flags for out-of-range or protected accesses
//   - continuously exported low registers, each with an update pulse
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   WrEn          write request
//   WrAddr        write address
//   WrData        write data
//   WrStrb        byte enables for the write
//   RdEn          read request
//   RdAddr        read address
//   RdData        read data; holds its last value while RdData_valid=0
//   RdData_valid  one-cycle qualifier for RdData and RdErr
//   RdErr         read address was >= DEPTH (RdData is 0 in that case)
//   WrErr         one-cycle pulse, the cycle after a rejected write
//   REG_EXPORT    registers 0..NUM_EXPORT-1, register i at
//                 [i*DATA_WIDTH +: DATA_WIDTH]
//   REG_UPDATED   per export register: one-cycle pulse after an accepted
//                 write that changed its value
//
// Handshake: neither port has a ready signal.
//   - A write is consumed on every CLK edge where WrEn=1.
//   - A read is consumed on every CLK edge where RdEn=1, so reads may be
//     issued back to back every cycle.
//   - Each accepted read produces exactly one RdData_valid pulse,
//     RD_LATENCY cycles later, in issue order.
//   - There is no back-pressure on the read return.
// ---------------------------------------------------------------------------
module reg_file_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int NUM_EXPORT = 4,
  parameter int RD_LATENCY = 1,
  parameter logic [DEPTH*DATA_WIDTH-1:0] RESET_VECTOR =
    ((DEPTH*DATA_WIDTH)'(8'h81) << (2*DATA_WIDTH)) |
    ((DEPTH*DATA_WIDTH)'(8'h20) << (3*DATA_WIDTH)),
  parameter logic [DEPTH-1:0] WP_MASK = '0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             WrEn,
  input  logic [ADDR_WIDTH-1:0]            WrAddr,
  input  logic [DATA_WIDTH-1:0]            WrData,
  input  logic [DATA_WIDTH/8-1:0]          WrStrb,
  input  logic                             RdEn,
  input  logic [ADDR_WIDTH-1:0]            RdAddr,
  output logic [DATA_WIDTH-1:0]            RdData,
  output logic                             RdData_valid,
  output logic                             RdErr,
  output logic                             WrErr,
  output logic [NUM_EXPORT*DATA_WIDTH-1:0] REG_EXPORT,
  output logic [NUM_EXPORT-1:0]            REG_UPDATED
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  // Register storage
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Write-side decode
  logic                  wr_hit;      // WrAddr names an implemented register
  logic                  wr_prot;     // addressed register is protected
  logic [DATA_WIDTH-1:0] wr_old;      // current value of addressed register
  logic [DATA_WIDTH-1:0] strb_mask;   // WrStrb expanded to bit granularity
  logic [DATA_WIDTH-1:0] wr_merged;   // value the register takes on accept
  logic                  wr_accept;
  logic                  wr_reject;
  logic [NUM_EXPORT-1:0] upd_next;

  // Read-side decode and first pipeline stage
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_v1;
  logic [DATA_WIDTH-1:0] rd_d1;
  logic                  rd_e1;

  // -------------------------------------------------------------------------
  // Address decode.
  // Both addresses are compared against each implemented index, rather than
  // indexing the array directly. An address >= DEPTH then simply fails to
  // hit, and never reaches past the end of the storage.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_hit  = 1'b0;
    wr_prot = 1'b0;
    wr_old  = '0;
    rd_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (WrAddr == ADDR_WIDTH'(i)) begin
        wr_hit  = 1'b1;
        wr_prot = WP_MASK[i];
        wr_old  = regs[i];
      end
      if (RdAddr == ADDR_WIDTH'(i)) begin
        rd_hit  = 1'b1;
        rd_word = regs[i];
      end
    end
  end

  always_comb begin
    strb_mask = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      strb_mask[k*8 +: 8] = {8{WrStrb[k]}};
    end
  end

  assign wr_merged = (wr_old & ~strb_mask) | (WrData & strb_mask);

  // WrStrb=0 to a writable register counts as accepted. It changes nothing,
  // so it produces neither an error nor an update pulse.
  assign wr_accept = WrEn &  (wr_hit & ~wr_prot);
  assign wr_reject = WrEn & ~(wr_hit & ~wr_prot);

  always_comb begin
    upd_next = '0;
    for (int i = 0; i < NUM_EXPORT; i++) begin
      upd_next[i] = wr_accept && (WrAddr == ADDR_WIDTH'(i)) &&
                    (wr_merged != wr_old);
    end
  end

  // -------------------------------------------------------------------------
  // Register array.
  // Protected registers are excluded from the write condition itself, so
  // they hold their reset value by construction.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VECTOR[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (wr_accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((WrAddr == ADDR_WIDTH'(i)) && !WP_MASK[i]) begin
          regs[i] <= wr_merged;
        end
      end
    end
  end

  // Write status pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WrErr       <= 1'b0;
      REG_UPDATED <= '0;
    end else begin
      WrErr       <= wr_reject;
      REG_UPDATED <= upd_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read stage 1.
  // The array is sampled on the same edge that may also write it. A read
  // that coincides with a write to the same address therefore returns the
  // pre-write value.
  // Data and error only load on an accepted read, so they hold between
  // reads.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
      rd_e1 <= 1'b0;
    end else begin
      rd_v1 <= RdEn;
      if (RdEn) begin
        rd_d1 <= rd_hit ? rd_word : '0;
        rd_e1 <= ~rd_hit;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_rd_lat2
      // An extra output register. Stage 1 still samples on the same edge
      // as in the single-cycle configuration, so only the return is delayed.
      logic                  rd_v2;
      logic [DATA_WIDTH-1:0] rd_d2;
      logic                  rd_e2;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rd_v2 <= 1'b0;
          rd_d2 <= '0;
          rd_e2 <= 1'b0;
        end else begin
          rd_v2 <= rd_v1;
          if (rd_v1) begin
            rd_d2 <= rd_d1;
            rd_e2 <= rd_e1;
          end
        end
      end

      assign RdData       = rd_d2;
      assign RdData_valid = rd_v2;
      assign RdErr        = rd_e2;
    end else begin : g_rd_lat1
      assign RdData       = rd_d1;
      assign RdData_valid = rd_v1;
      assign RdErr        = rd_e1;
    end
  endgenerate

  // Exported registers: straight from register state, no added latency.
  generate
    for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
      assign REG_EXPORT[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_cfg.sv
// ---------------------------------------------------------------------------
// tb_reg_file_cfg
//
// Two instances of reg_file_cfg:
//   dut_a: 8-bit registers, DEPTH=12, register 3 write-protected,
//          1-cycle read latency.
//   dut_b: 16-bit registers, DEPTH=16, 2-cycle read latency.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file_cfg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- dut_a signals ----------------
  logic        a_rst, a_wr_en, a_wr_strb, a_rd_en;
  logic [3:0]  a_wr_addr, a_rd_addr;
  logic [7:0]  a_wr_data, a_rd_data;
  logic        a_rd_valid, a_rd_err, a_wr_err;
  logic [31:0] a_export;
  logic [3:0]  a_upd;

  // ---------------- dut_b signals ----------------
  logic        b_rst, b_wr_en, b_rd_en;
  logic [1:0]  b_wr_strb;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [15:0] b_wr_data, b_rd_data;
  logic        b_rd_valid, b_rd_err, b_wr_err;
  logic [63:0] b_export;
  logic [3:0]  b_upd;

  reg_file_cfg #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .NUM_EXPORT(4),
    .RD_LATENCY(1), .WP_MASK(12'h008)
  ) dut_a (
    .CLK(clk), .RST(a_rst),
    .WrEn(a_wr_en), .WrAddr(a_wr_addr), .WrData(a_wr_data), .WrStrb(a_wr_strb),
    .RdEn(a_rd_en), .RdAddr(a_rd_addr),
    .RdData(a_rd_data), .RdData_valid(a_rd_valid), .RdErr(a_rd_err),
    .WrErr(a_wr_err), .REG_EXPORT(a_export), .REG_UPDATED(a_upd)
  );

  reg_file_cfg #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .NUM_EXPORT(4),
    .RD_LATENCY(2)
  ) dut_b (
    .CLK(clk), .RST(b_rst),
    .WrEn(b_wr_en), .WrAddr(b_wr_addr), .WrData(b_wr_data), .WrStrb(b_wr_strb),
    .RdEn(b_rd_en), .RdAddr(b_rd_addr),
    .RdData(b_rd_data), .RdData_valid(b_rd_valid), .RdErr(b_rd_err),
    .WrErr(b_wr_err), .REG_EXPORT(b_export), .REG_UPDATED(b_upd)
  );

  // ---------------- common compare ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- dut_a vector table ----------------
  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_strb;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_err;
    logic        exp_wr_err;
    logic [3:0]  exp_upd;
    logic [31:0] exp_export;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic we, input logic [3:0] wa, input logic [7:0] wd, input logic ws,
    input logic re, input logic [3:0] ra,
    input logic ev, input logic [7:0] ed, input logic ee, input logic ewe,
    input logic [3:0] eu, input logic [31:0] ex);
    vec_t t;
    t.wr_en = we;  t.wr_addr = wa;  t.wr_data = wd;  t.wr_strb = ws;
    t.rd_en = re;  t.rd_addr = ra;
    t.exp_valid = ev; t.exp_data = ed; t.exp_err = ee; t.exp_wr_err = ewe;
    t.exp_upd = eu; t.exp_export = ex;
    return t;
  endfunction

  task automatic a_drive(input vec_t t);
    a_wr_en = t.wr_en; a_wr_addr = t.wr_addr; a_wr_data = t.wr_data; a_wr_strb = t.wr_strb;
    a_rd_en = t.rd_en; a_rd_addr = t.rd_addr;
  endtask

  task automatic a_idle();
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_wr_strb = 0; a_rd_en = 0; a_rd_addr = 0;
  endtask

  // ---------------- dut_b driver + scoreboard ----------------
  logic [15:0] exp_q [$];
  int          due_q [$];
  int          b_valid_cnt = 0;

  task automatic b_cycle(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [1:0] ws, input logic re, input logic [3:0] ra,
                         input logic [15:0] ed);
    @(negedge clk);
    b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_wr_strb = ws;
    b_rd_en = re; b_rd_addr = ra;
    if (re) begin
      exp_q.push_back(ed);
      due_q.push_back(cyc + 2);
    end
  endtask

  task automatic b_idle();
    @(negedge clk);
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_strb = 0; b_rd_en = 0; b_rd_addr = 0;
  endtask

  task automatic b_drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Return monitor: every valid must match the oldest expected read,
  // in its exact due cycle.
  always @(negedge clk) begin
    if (!b_rst && b_rd_valid) begin
      b_valid_cnt++;
      if (exp_q.size() == 0) begin
        check("b_unexpected_valid", 64'(b_rd_valid), 64'd0);
      end else begin
        logic [15:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("b_rd_data", 64'(b_rd_data), 64'(e));
        check("b_rd_cycle", 64'(cyc), 64'(d));
        check("b_rd_err", 64'(b_rd_err), 64'd0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt_before;

    a_rst = 1; b_rst = 1;
    a_idle();
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_strb = 0; b_rd_en = 0; b_rd_addr = 0;

    // Vector table for dut_a
    //           we wa  wd     ws re ra   ev ed     ee ewe eu       export
    vecs[0]  = mk(0, 0, 8'h00, 0, 1, 2,   1, 8'h81, 0, 0, 4'b0000, 32'h2081_0000);
    vecs[1]  = mk(0, 0, 8'h00, 0, 0, 0,   0, 8'h81, 0, 0, 4'b0000, 32'h2081_0000);
    vecs[2]  = mk(1, 3, 8'hFF, 1, 0, 0,   0, 8'h81, 0, 1, 4'b0000, 32'h2081_0000);
    vecs[3]  = mk(0, 0, 8'h00, 0, 0, 0,   0, 8'h81, 0, 0, 4'b0000, 32'h2081_0000);
    vecs[4]  = mk(0, 0, 8'h00, 0, 1, 3,   1, 8'h20, 0, 0, 4'b0000, 32'h2081_0000);
    vecs[5]  = mk(1, 14, 8'h77, 1, 1, 14, 1, 8'h00, 1, 1, 4'b0000, 32'h2081_0000);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 4'b0000, 32'h2081_0000);
    vecs[7]  = mk(1, 1, 8'h55, 1, 1, 1,   1, 8'h00, 0, 0, 4'b0010, 32'h2081_5500);
    vecs[8]  = mk(0, 0, 8'h00, 0, 1, 1,   1, 8'h55, 0, 0, 4'b0000, 32'h2081_5500);
    vecs[9]  = mk(1, 1, 8'h55, 1, 0, 0,   0, 8'h55, 0, 0, 4'b0000, 32'h2081_5500);
    vecs[10] = mk(1, 0, 8'hAA, 0, 0, 0,   0, 8'h55, 0, 0, 4'b0000, 32'h2081_5500);
    vecs[11] = mk(1, 0, 8'hA5, 1, 1, 2,   1, 8'h81, 0, 0, 4'b0001, 32'h2081_55A5);
    vecs[12] = mk(1, 11, 8'h3C, 1, 0, 0,  0, 8'h81, 0, 0, 4'b0000, 32'h2081_55A5);
    vecs[13] = mk(0, 0, 8'h00, 0, 1, 11,  1, 8'h3C, 0, 0, 4'b0000, 32'h2081_55A5);
    vecs[14] = mk(1, 12, 8'h99, 1, 1, 12, 1, 8'h00, 1, 1, 4'b0000, 32'h2081_55A5);
    vecs[15] = mk(1, 2, 8'h81, 1, 0, 0,   0, 8'h00, 0, 0, 4'b0000, 32'h2081_55A5);
    vecs[16] = mk(1, 2, 8'h7E, 1, 0, 0,   0, 8'h00, 0, 0, 4'b0100, 32'h207E_55A5);
    vecs[17] = mk(0, 0, 8'h00, 0, 1, 2,   1, 8'h7E, 0, 0, 4'b0000, 32'h207E_55A5);

    repeat (3) @(negedge clk);
    a_rst = 0; b_rst = 0;
    @(negedge clk);

    // Reset state
    check("a_rst_data",   64'(a_rd_data),  64'd0);
    check("a_rst_valid",  64'(a_rd_valid), 64'd0);
    check("a_rst_err",    64'(a_rd_err),   64'd0);
    check("a_rst_wr_err", 64'(a_wr_err),   64'd0);
    check("a_rst_upd",    64'(a_upd),      64'd0);
    check("a_rst_export", 64'(a_export),   64'h2081_0000);
    check("b_rst_valid",  64'(b_rd_valid), 64'd0);
    check("b_rst_data",   64'(b_rd_data),  64'd0);
    check("b_rst_export", b_export,        64'h0020_0081_0000_0000);

    // dut_a table: drive at a negedge, compare one cycle later
    a_drive(vecs[0]);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check($sformatf("a_v%0d_valid", i), 64'(a_rd_valid), 64'(vecs[i].exp_valid));
      check($sformatf("a_v%0d_data", i),  64'(a_rd_data),  64'(vecs[i].exp_data));
      if (vecs[i].exp_valid)
        check($sformatf("a_v%0d_rd_err", i), 64'(a_rd_err), 64'(vecs[i].exp_err));
      check($sformatf("a_v%0d_wr_err", i), 64'(a_wr_err), 64'(vecs[i].exp_wr_err));
      check($sformatf("a_v%0d_upd", i),    64'(a_upd),    64'(vecs[i].exp_upd));
      check($sformatf("a_v%0d_export", i), 64'(a_export), 64'(vecs[i].exp_export));
      if (i + 1 < NV) a_drive(vecs[i+1]);
      else a_idle();
    end

    // dut_b: byte strobes on a 16-bit register
    b_cycle(1, 5, 16'hABCD, 2'b01, 0, 0, 16'h0000);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 5, 16'h00CD);
    b_cycle(1, 5, 16'h1234, 2'b10, 0, 0, 16'h0000);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 5, 16'h12CD);
    b_idle();
    b_drain("b_drain_strb");

    // dut_b: four back-to-back reads return on four consecutive cycles
    b_cycle(1, 0, 16'h1111, 2'b11, 0, 0, 16'h0000);
    b_cycle(1, 1, 16'h2222, 2'b11, 0, 0, 16'h0000);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 0, 16'h1111);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 1, 16'h2222);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 2, 16'h0081);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 3, 16'h0020);
    b_idle();
    b_drain("b_drain_burst");

    // dut_b: same-cycle read/write returns the old value
    b_cycle(1, 1, 16'h3333, 2'b11, 1, 1, 16'h2222);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 1, 16'h3333);
    b_idle();
    b_drain("b_drain_rbw");
    check("b_export_written", b_export, 64'h0020_0081_3333_1111);

    // dut_b: reset while a read is in flight
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 0, 16'h1111);
    @(negedge clk);
    b_rd_en = 0; b_rd_addr = 0;
    b_rst = 1;
    exp_q.delete();
    due_q.delete();
    cnt_before = b_valid_cnt;
    @(negedge clk);
    b_rst = 0;
    repeat (4) @(negedge clk);
    check("b_no_valid_after_rst", 64'(b_valid_cnt), 64'(cnt_before));
    check("b_rst2_data",   64'(b_rd_data), 64'd0);
    check("b_rst2_export", b_export,       64'h0020_0081_0000_0000);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 5, 16'h0000);
    b_cycle(0, 0, 16'h0000, 2'b00, 1, 2, 16'h0081);
    b_idle();
    b_drain("b_drain_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
